// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch stage: word width, NOP encoding,
// fetch FSM states and the {pc, instr} payload carried by IF/ID and the skid buffer.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_word_t;

  // Sequential PC, wraps modulo 2^32
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory busywait handshake between the fetch unit (master) and memory (slave).
interface instruction_fetch_unit_if;
  import rv32_pkg::*;

  logic            imem_read;
  logic [XLEN-1:0] imem_address;
  logic [XLEN-1:0] imem_readdata;
  logic            imem_busywait;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_readdata,
    input  imem_busywait
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_readdata,
    output imem_busywait
  );

endinterface

// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register: reset > flush > load, otherwise holds.
// A flush turns the slot into a bubble but leaves the PC fields untouched.
module if_id_pipeline_register
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  fetch_word_t     d,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic [XLEN-1:0] instruction,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_out       <= '0;
      pc_plus4_out <= '0;
      instruction  <= NOP_INSTR;
      valid        <= 1'b0;
    end else if (flush) begin
      instruction  <= NOP_INSTR;
      valid        <= 1'b0;
    end else if (load) begin
      pc_out       <= d.pc;
      pc_plus4_out <= pc_incr(d.pc);
      instruction  <= d.instr;
      valid        <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues busywait requests to instruction memory, and feeds IF/ID.
// Handles decode stall through a one-entry skid buffer and EX redirects, including mid-fetch.
module instruction_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  imem,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [XLEN-1:0]           branch_target,
  output logic                      fetch_busy,
  output logic [XLEN-1:0]           pc_out,
  output logic [XLEN-1:0]           pc_plus4_out,
  output logic [XLEN-1:0]           instruction,
  output logic                      valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            read_q, read_d;
  logic [XLEN-1:0] addr_q, addr_d;
  fetch_word_t     skid_q, skid_d;
  fetch_word_t     ifid_d;
  logic            ifid_load;
  logic            ifid_flush;
  logic [XLEN-1:0] target;

  // Targets are word aligned; the low two bits are simply cleared
  assign target = branch_target & ~XLEN'(3);

  assign imem.imem_read    = read_q;
  assign imem.imem_address = addr_q;

  assign fetch_busy = ((state_q == FETCH) && read_q && imem.imem_busywait)
                    || (state_q == DISCARD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      read_q <= 1'b0;
      addr_q <= RESET_PC;
      skid_q <= '0;
    end else begin
      pc_q   <= pc_d;
      read_q <= read_d;
      addr_q <= addr_d;
      skid_q <= skid_d;
    end
  end

  // Next-state, PC/request update and IF/ID control; priority is redirect > stall
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    read_d       = read_q;
    addr_d       = addr_q;
    skid_d       = skid_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_d.pc    = pc_q;
    ifid_d.instr = imem.imem_readdata;

    case (state_q)
      FETCH: begin
        if (branch_taken) begin
          pc_d       = target;
          ifid_flush = 1'b1;
          if (read_q && imem.imem_busywait) begin
            // Memory cannot abort the request; drain it in DISCARD
            state_d = DISCARD;
          end else begin
            read_d = 1'b1;
            addr_d = target;
          end
        end else if (!read_q) begin
          read_d = 1'b1;
          addr_d = pc_q;
        end else if (!imem.imem_busywait) begin
          if (stall && valid) begin
            skid_d.pc    = pc_q;
            skid_d.instr = imem.imem_readdata;
            pc_d         = pc_incr(pc_q);
            read_d       = 1'b0;
            state_d      = HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_incr(pc_q);
            addr_d    = pc_incr(pc_q);
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          skid_d     = '0;
          ifid_flush = 1'b1;
          pc_d       = target;
          read_d     = 1'b1;
          addr_d     = target;
          state_d    = FETCH;
        end else if (!stall) begin
          ifid_load = 1'b1;
          ifid_d    = skid_q;
          skid_d    = '0;
          read_d    = 1'b1;
          addr_d    = pc_q;
          state_d   = FETCH;
        end
      end

      DISCARD: begin
        if (branch_taken) begin
          pc_d       = target;
          ifid_flush = 1'b1;
        end
        if (!imem.imem_busywait) begin
          read_d  = 1'b1;
          addr_d  = branch_taken ? target : pc_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  if_id_pipeline_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .load         (ifid_load),
    .flush        (ifid_flush),
    .d            (ifid_d),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .instruction  (instruction),
    .valid        (valid)
  );

endmodule
